// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and request legality check for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACCESS = 2'b01;
  localparam logic [1:0] S_RESP   = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Stores only exist for B/H/W; loads add the unsigned BU/HU forms.
  function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic legal;
    logic aligned;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    case (f3_size(f3))
      SZ_HALF: aligned = (lo[0] == 1'b0);
      SZ_WORD: aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication/strobes and load lane extract/extend
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (f3_size(st_funct3))
      SZ_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      SZ_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << st_addr_lo;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    ld_shifted = ld_word >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - handshaked load/store unit: FSM, request latches, timeout, response
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic          mem_we_q, mem_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic          req_legal;
  logic          timed_out;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   ld_data;

  lsu_lane_align u_align (
    .st_funct3  (req_funct3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  assign req_legal = req_ok(req_we, req_funct3, req_addr[1:0]);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_we_d     = mem_we_q;
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          addr_lo_d  = req_addr[1:0];
          mem_addr_d = {req_addr[31:2], 2'b00};
          cnt_d      = '0;
          if (req_legal) begin
            mem_wdata_d = st_wdata;
            mem_wstrb_d = req_we ? st_wstrb : 4'b0000;
            mem_we_d    = req_we;
            state_d     = S_ACCESS;
          end else begin
            // Rejected requests answer with an error without touching memory.
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack || timed_out) begin
          resp_err_d   = !mem_ack;
          resp_rdata_d = (mem_ack && !we_q) ? ld_data : 32'h0;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_we_q     <= 1'b0;
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_we_q     <= mem_we_d;
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_req    = (state_q == S_ACCESS);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed vector bench for lsu_mem_stage with TIMEOUT=4
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // ack_at: mem_req cycle (1-based) on which mem_ack is driven; 0 = never.
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ack_at;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nreq;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_maddr;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   nreq;
    int   lat;
    logic got_err;
    logic [31:0] got_rdata;
    v = vt[i];
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check("req_ready", i, {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    nreq      = 0;
    lat       = 0;
    got_err   = 1'b0;
    got_rdata = 32'h0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        nreq++;
        if (nreq == 1) begin
          check("mem_addr", i, mem_addr, v.exp_maddr);
          check("mem_wstrb", i, {28'h0, mem_wstrb}, {28'h0, v.exp_strb});
          check("mem_we", i, {31'h0, mem_we}, {31'h0, v.we});
          if (v.we) check("mem_wdata", i, mem_wdata, v.exp_wdata);
        end
        if (nreq == v.ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mrdata;
        end
      end
      if (resp_valid) begin
        lat       = c;
        got_err   = resp_err;
        got_rdata = resp_rdata;
      end
    end
    mem_ack = 1'b0;
    check("resp_latency", i, lat, v.exp_lat);
    check("mem_req_cycles", i, nreq, v.exp_nreq);
    check("resp_err", i, {31'h0, got_err}, {31'h0, v.exp_err});
    check("resp_rdata", i, got_rdata, v.exp_rdata);
    @(negedge clk);
    check("resp_pulse_end", i, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rv;
    int seen;

    //           we    f3      addr      wdata         mrdata        ack err  rdata         lat nreq strb     wdata         maddr
    vt[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1, 1'b0, 32'h0,        2, 1, 4'b1111, 32'hDEADBEEF, 32'h10};
    vt[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h80FF0000, 1, 1'b0, 32'hFFFFFF80, 2, 1, 4'b0000, 32'h0,        32'h10};
    vt[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h80FF0000, 1, 1'b0, 32'h00000080, 2, 1, 4'b0000, 32'h0,        32'h10};
    vt[3]  = '{1'b0, 3'b001, 32'h06, 32'h0,        32'h80011234, 1, 1'b0, 32'hFFFF8001, 2, 1, 4'b0000, 32'h0,        32'h04};
    vt[4]  = '{1'b1, 3'b001, 32'h02, 32'h0000ABCD, 32'h0,        1, 1'b0, 32'h0,        2, 1, 4'b1100, 32'hABCDABCD, 32'h00};
    vt[5]  = '{1'b0, 3'b010, 32'h21, 32'h0,        32'h0,        1, 1'b1, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0};
    vt[6]  = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1, 1'b1, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 3'b100, 32'h00, 32'h0,        32'h0,        1, 1'b1, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0};
    vt[8]  = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h0,        0, 1'b1, 32'h0,        5, 4, 4'b0000, 32'h0,        32'h40};
    vt[9]  = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h12345678, 4, 1'b0, 32'h12345678, 5, 4, 4'b0000, 32'h0,        32'h40};
    vt[10] = '{1'b1, 3'b000, 32'h01, 32'h0000005A, 32'h0,        1, 1'b0, 32'h0,        2, 1, 4'b0010, 32'h5A5A5A5A, 32'h00};
    vt[11] = '{1'b0, 3'b101, 32'h02, 32'h0,        32'h80017FFF, 1, 1'b0, 32'h00008001, 2, 1, 4'b0000, 32'h0,        32'h00};
    vt[12] = '{1'b1, 3'b000, 32'h57, 32'h000000C3, 32'h0,        3, 1'b0, 32'h0,        4, 3, 4'b1000, 32'hC3C3C3C3, 32'h54};
    vt[13] = '{1'b0, 3'b001, 32'h03, 32'h0,        32'h0,        1, 1'b1, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 0, {31'h0, req_ready}, 32'h1);
    check("rst_busy", 0, {31'h0, busy}, 32'h0);
    check("rst_mem_req", 0, {31'h0, mem_req}, 32'h0);
    check("rst_resp_valid", 0, {31'h0, resp_valid}, 32'h0);
    check("rst_mem_addr", 0, mem_addr, 32'h0);
    check("rst_mem_wstrb", 0, {28'h0, mem_wstrb}, 32'h0);
    check("rst_resp_rdata", 0, resp_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset while an access is outstanding: the access vanishes without a response.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h80;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_mem_req_before", 0, {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_req", 0, {31'h0, mem_req}, 32'h0);
    check("abort_busy", 0, {31'h0, busy}, 32'h0);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_resp", 0, seen, 0);

    // Continuous requests with ack held high: one accept every three cycles.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    acc = 0;
    rv  = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) acc++;
      if (resp_valid) begin
        rv++;
        check("b2b_rdata", c, resp_rdata, 32'hCAFEF00D);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    check("b2b_accepts", 0, acc, 4);
    check("b2b_resps", 0, rv, 4);
    repeat (3) @(negedge clk);
    check("final_idle", 0, {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
